// File: rtl/led_serial_driver.sv
// Parallel-to-serial driver for a cascaded LED shift-register chain:
// clear pulse, bit-serial stream with its own shift clock, then a latch-enable pulse.
module led_serial_driver #(
    parameter int unsigned DATA_BITS       = 16,
    parameter int unsigned DATA_COUNT_BITS = 4,
    parameter int unsigned DIR             = 0,
    parameter int unsigned HALF_PERIOD     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic [DATA_BITS-1:0] PData,
    output logic                 sclk,
    output logic                 sclrn,
    output logic                 sout,
    output logic                 EN,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    localparam logic [7:0]                 PHASE_RELOAD = 8'(HALF_PERIOD - 1);
    localparam logic [DATA_COUNT_BITS-1:0] LAST_BIT     = DATA_COUNT_BITS'(DATA_BITS - 1);

    state_t                     state_q, state_d;
    logic [7:0]                 phase_q, phase_d;
    logic [DATA_COUNT_BITS-1:0] cnt_q, cnt_d;
    logic [DATA_BITS-1:0]       shreg_q, shreg_d;
    logic                       start_prev_q, start_prev_d;
    logic                       sclk_q, sclk_d;
    logic                       sclrn_q, sclrn_d;
    logic                       sout_q, sout_d;
    logic                       en_q, en_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       start_edge;
    logic                       phase_end;
    logic                       head_bit;
    logic                       shifted_head;
    logic [DATA_BITS-1:0]       shifted;

    // Head bit is the one driven next; shifting moves the following bit into it.
    always_comb begin
        if (DIR == 0) begin
            head_bit = shreg_q[DATA_BITS-1];
            shifted  = {shreg_q[DATA_BITS-2:0], 1'b0};
            shifted_head = shifted[DATA_BITS-1];
        end else begin
            head_bit = shreg_q[0];
            shifted  = {1'b0, shreg_q[DATA_BITS-1:1]};
            shifted_head = shifted[0];
        end
    end

    always_comb begin
        start_edge   = Start & ~start_prev_q;
        phase_end    = (phase_q == 8'd0);

        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        shreg_d      = shreg_q;
        start_prev_d = Start;
        sclk_d       = sclk_q;
        sclrn_d      = sclrn_q;
        sout_d       = sout_q;
        en_d         = en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;

        if (state_q != IDLE) begin
            phase_d = phase_end ? PHASE_RELOAD : phase_q - 8'd1;
        end

        case (state_q)
            IDLE: begin
                sclk_d  = 1'b0;
                sclrn_d = 1'b1;
                en_d    = 1'b0;
                if (start_edge) begin
                    shreg_d = PData;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    sclrn_d = 1'b0;
                    phase_d = PHASE_RELOAD;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (phase_end) begin
                    sclrn_d = 1'b1;
                    sout_d  = head_bit;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    if (cnt_q == LAST_BIT) begin
                        en_d    = 1'b1;
                        state_d = LATCH;
                    end else begin
                        cnt_d   = cnt_q + DATA_COUNT_BITS'(1);
                        shreg_d = shifted;
                        sout_d  = shifted_head;
                        state_d = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (phase_end) begin
                    en_d    = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sout_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= '0;
            cnt_q        <= '0;
            shreg_q      <= '0;
            start_prev_q <= 1'b0;
            sclk_q       <= 1'b0;
            sclrn_q      <= 1'b1;
            sout_q       <= 1'b0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            start_prev_q <= start_prev_d;
            sclk_q       <= sclk_d;
            sclrn_q      <= sclrn_d;
            sout_q       <= sout_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sclk  = sclk_q;
    assign sclrn = sclrn_q;
    assign sout  = sout_q;
    assign EN    = en_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/led_serial_driver.md
Name: led_serial_driver

Overview:
- Parallel-to-serial driver for the board's cascaded LED shift registers (74HC164/595-style chain).
- Sits directly downstream of the GPIO output register. It takes the 16-bit (inverted) LED word plus a Start strobe and emits a clear pulse, a bit-serial stream with its own shift clock, and a final latch-enable pulse.
- Also provides busy/done status so the CPU-side GPIO logic can pace refreshes.

Parameters:
- DATA_BITS, 16: width of the parallel word shifted out.
- DATA_COUNT_BITS, 4: bit-counter width; must satisfy 2^DATA_COUNT_BITS >= DATA_BITS.
- DIR, 0: shift order. 0 = MSB first (PData[DATA_BITS-1] first); 1 = LSB first.
- HALF_PERIOD, 1: clk cycles per serial phase (sclk half-period, clear width, latch width). Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- Start  input  1  transfer request; rising edge (Start=1, previous-cycle Start=0) triggers.
- PData  input  DATA_BITS  parallel word, sampled only on an accepted Start edge.
- sclk  output  1  serial shift clock to the chain; receiver samples sout on the sclk rising edge.
- sclrn  output  1  active-low chain clear.
- sout  output  1  serial data.
- EN  output  1  active-high output-latch enable pulse after the last bit.
- busy  output  1  high from accepted Start until return to IDLE.
- done  output  1  one-clk pulse on completion of a transfer.

Behaviour:
- Reset state (rst=1 at posedge, including mid-transfer): FSM=IDLE, sclk=0, sclrn=1, sout=0, EN=0, busy=0, done=0, shift register=0, counters=0, Start history=0.
  - Reset mid-transfer produces no EN pulse and no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, CLEAR, SHIFT_LO, SHIFT_HI, LATCH. Every non-IDLE state lasts exactly HALF_PERIOD clks, timed by an 8-bit phase counter that reloads on each state entry.
- IDLE: sclk=0, sclrn=1, EN=0.
  - On a Start rising edge: load PData into the shift register, clear the bit counter, set busy=1, go to CLEAR.
  - Start held high does not retrigger; a new rising edge is required.
- CLEAR: sclrn=0, sclk=0. Then go to SHIFT_LO with sclrn=1.
- SHIFT_LO: sclk=0; sout = the current head bit (MSB if DIR=0, LSB if DIR=1). Then go to SHIFT_HI.
- SHIFT_HI: sclk=1; sout held stable for the whole phase. At phase end:
  - If bit counter == DATA_BITS-1, go to LATCH.
  - Otherwise increment the counter, shift the register by one toward the head (zero-fill), and go to SHIFT_LO.
- LATCH: sclk=0, EN=1. At phase end: EN=0, busy=0, done=1 for one clk, go to IDLE.
- Total busy duration = HALF_PERIOD*(2*DATA_BITS+2) clks. With defaults: 34 clks.
- Start edges while busy are ignored and are not queued.
- A Start edge in the same cycle that done=1 (first IDLE cycle) is accepted.
- PData changes while busy have no effect on the transfer in progress.
- sout after LATCH returns to 0 in IDLE.

Test Plan:
- Reset, then hold Start=0 for 10 clks -> sclk=0, sclrn=1, sout=0, EN=0, busy=0, done=0 throughout.
- Defaults, PData=16'hA5C3, one Start edge -> sclrn low for exactly 1 clk; 16 sclk rising edges; sout sampled at those edges reconstructs MSB-first 16'hA5C3; EN high for exactly 1 clk after the 16th edge; busy high for 34 clks; done pulses once.
- DIR=1, HALF_PERIOD=3, PData=16'h0001 -> first sampled bit=1, remaining 15 bits=0; each sclk high/low phase is 3 clks; busy high for 102 clks.
- Start held high 100 clks with PData=16'hFFFF -> exactly one transfer (16 sclk edges, one EN pulse); change PData to 16'h0000 mid-shift -> sampled stream still all ones.
- Assert rst for 1 clk after the 5th sclk rising edge -> next cycle all outputs at reset values; no EN or done pulse; a fresh Start edge performs a complete, correct transfer.
- Issue a second Start edge mid-transfer -> ignored. Issue a Start edge in the done cycle -> a second transfer begins immediately, with sclrn low on the following clk.
